// File: rtl/cfg_seq_ctrl_pkg.sv
// Shared types and defaults for the sensor config sequencer.
// State encoding is common to the scan FSM and cfg_seq_ctrl.
package cfg_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SRST   = 3'd1,
    S_FETCH  = 3'd2,
    S_LOAD   = 3'd3,
    S_WAIT   = 3'd4,
    S_NEXT   = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  localparam int LEN_DEF        = 7;
  localparam int N_WORDS_DEF    = 24;
  localparam int RST_CYCLES_DEF = 4;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_seq_ctrl_cnt.sv
// Loadable down-counter with zero flag.
// Times the sensor reset pulse; saturates at zero.
module cfg_seq_cnt
  import cfg_seq_ctrl_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt_q;

  // Load has priority over decrement; never wraps below zero.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/cfg_seq_ctrl.sv
// Sensor config sequencer: reset pulse, then fetch words
// from sync memory and hand them to the cfg shift register.
module cfg_seq_ctrl
  import cfg_seq_ctrl_pkg::*;
#(
  parameter int LEN        = LEN_DEF,
  parameter int N_WORDS    = N_WORDS_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int ADDR_W     = clog2_min1(N_WORDS)
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [LEN-1:0]    i_mem_data,
  output logic              o_sr_load,
  output logic [LEN-1:0]    o_sr_data,
  input  logic              i_sr_ready,
  output logic              o_sens_rst,
  output logic              o_sens_en,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = clog2_min1(RST_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0]  RST_LD   = CNT_W'(RST_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              pend_q, pend_d;
  logic              guard_q, guard_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              load_d;
  logic              abort_now;

  assign abort_now = i_abort | pend_q;

  cfg_seq_cnt #(
    .W (CNT_W)
  ) u_rst_cnt (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_load     (cnt_load),
    .i_load_val (RST_LD),
    .i_dec      (cnt_dec),
    .o_zero     (cnt_zero)
  );

  // Next-state, word index, abort latch and load strobe decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    guard_d  = guard_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    load_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          state_d  = S_SRST;
          idx_d    = '0;
          cnt_load = 1'b1;
        end
      end
      S_SRST: begin
        if (abort_now)     state_d = S_IDLE;
        else if (cnt_zero) state_d = S_FETCH;
        else               cnt_dec = 1'b1;
      end
      S_FETCH: begin
        state_d = abort_now ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        if (abort_now) begin
          state_d = S_IDLE;
        end else if (i_sr_ready) begin
          load_d  = 1'b1;
          guard_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ready is stale in the load cycle; skip it once.
        if (guard_q)         guard_d = 1'b0;
        else if (i_sr_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (abort_now) begin
          state_d = S_IDLE;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    pend_d = (state_d == S_IDLE) ? 1'b0
           : (pend_q | ((state_q != S_IDLE) & i_abort));
  end

  // State, index and flag registers.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      guard_q <= guard_d;
    end
  end

  // Outputs registered from the upcoming state.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_mem_addr <= '0;
      o_mem_rd   <= 1'b0;
      o_sr_load  <= 1'b0;
      o_sr_data  <= '0;
      o_sens_rst <= 1'b0;
      o_sens_en  <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_mem_rd   <= (state_d == S_FETCH);
      if (state_d == S_FETCH) o_mem_addr <= idx_d;
      o_sr_load  <= load_d;
      if (load_d) o_sr_data <= i_mem_data;
      o_sens_rst <= (state_d == S_SRST);
      o_sens_en  <= (state_d inside {S_FETCH, S_LOAD, S_WAIT, S_NEXT});
      o_busy     <= (state_d != S_IDLE);
      o_done     <= (state_d == S_FINISH);
    end
  end

endmodule
